// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: ALU op codes, word type, ALU arbiter states
//
// Purpose:
//   Common definitions used by the ALU arbiter and its sub-modules.
//   - WORD_W / word_t : native datapath word.
//   - aluop_t         : 4-bit ALU operation code. ALU_SLL is encoded as zero
//                       so that a cleared op register means "shift by b".
//   - arb_state_t     : arbiter FSM states (IDLE, EXEC, RESP).
//   - req_onehot()    : maps a requester index to its one-hot strobe vector.
//
// Ports: none (package).

package cpu_types_pkg;

   localparam int unsigned WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [3:0] {
      ALU_SLL  = 4'h0,
      ALU_SRL  = 4'h1,
      ALU_SRA  = 4'h2,
      ALU_ADD  = 4'h3,
      ALU_SUB  = 4'h4,
      ALU_AND  = 4'h5,
      ALU_OR   = 4'h6,
      ALU_XOR  = 4'h7,
      ALU_SLT  = 4'h8,
      ALU_SLTU = 4'h9
   } aluop_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   // Requester index -> {strobe1, strobe0}.
   function automatic logic [1:0] req_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin pick with priority pointer register
//
// Purpose:
//   Picks one of two requesters. A lone request always wins; when both
//   request, the requester named by the priority pointer wins. The pointer
//   is only moved when the caller actually takes the grant, and it then
//   points at the loser so the other side is preferred next time.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset (pointer -> requester 0)
//   req      in   [1:0] request vector {req1, req0}
//   take     in   caller consumes the pick this cycle (pointer may advance)
//   any_req  out  at least one request present
//   winner   out  index of the selected requester (valid when any_req)

module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       take,
   output logic       any_req,
   output logic       winner
);

   // ptr_q holds the preferred requester for the next contended pick.
   logic ptr_q;
   logic ptr_d;

   always_comb begin
      any_req = |req;
      case (req)
         2'b01:   winner = 1'b0;
         2'b10:   winner = 1'b1;
         2'b11:   winner = ptr_q;
         default: winner = 1'b0;
      endcase

      ptr_d = ptr_q;
      if (take && any_req) begin
         ptr_d = ~winner;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU between two requesters
//
// Purpose:
//   Requester 0 (execute datapath) and requester 1 (branch/address compare)
//   share a single combinational ALU. A request is granted from IDLE, its
//   op/operands are registered onto the ALU inputs (EXEC), the ALU result and
//   flags are captured and held (RESP) until the owning requester acks.
//   Sequence per operation: grant edge -> capture edge -> ack edge, so the
//   minimum issue interval is three cycles.
//
// Optional feature (macro ALU_ARB_STATS_EN):
//   Adds saturating grant counters gcnt0/gcnt1 and a conflict counter
//   conflict_cnt (IDLE cycles with both requests high). Without the macro
//   those ports and registers are absent.
//
// Ports:
//   CLK, RST                      clock / asynchronous active-high reset
//   req0/1, op0/1, a0/b0, a1/b1   requests; op and operands stable until gnt
//   gnt0/1                        one-cycle grant pulse
//   rvalid0/1, rack0/1            result valid / acknowledge per requester
//   rdata, rzero, rneg, rovf      captured result and flags (shared)
//   alu_op, alu_a, alu_b          registered ALU input drive
//   alu_out, alu_zero/neg/ovf     ALU result and flags
//   gcnt0, gcnt1, conflict_cnt    statistics (ALU_ARB_STATS_EN only)

module alu_arbiter
   import cpu_types_pkg::*;
#(
   parameter int unsigned DATA_W = WORD_W,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              req0,
   input  logic              req1,
   input  aluop_t            op0,
   input  aluop_t            op1,
   input  logic [DATA_W-1:0] a0,
   input  logic [DATA_W-1:0] b0,
   input  logic [DATA_W-1:0] a1,
   input  logic [DATA_W-1:0] b1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   input  logic              rack0,
   input  logic              rack1,
   output logic [DATA_W-1:0] rdata,
   output logic              rzero,
   output logic              rneg,
   output logic              rovf,
   output aluop_t            alu_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_zero,
   input  logic              alu_neg,
   input  logic              alu_ovf
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [CNT_W-1:0]  gcnt0,
   output logic [CNT_W-1:0]  gcnt1,
   output logic [CNT_W-1:0]  conflict_cnt
`endif
);

   if (DATA_W < 2 || CNT_W < 1) begin : g_bad_params
      $error("alu_arbiter: DATA_W must be >= 2 and CNT_W >= 1");
   end

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   arb_state_t        state_q,  state_d;
   logic              owner_q,  owner_d;
   logic [1:0]        gnt_q,    gnt_d;
   logic [1:0]        rvalid_q, rvalid_d;
   logic [DATA_W-1:0] rdata_q,  rdata_d;
   logic              rzero_q,  rzero_d;
   logic              rneg_q,   rneg_d;
   logic              rovf_q,   rovf_d;
   aluop_t            alu_op_q, alu_op_d;
   logic [DATA_W-1:0] alu_a_q,  alu_a_d;
   logic [DATA_W-1:0] alu_b_q,  alu_b_d;

   logic [1:0]        rack;
   logic              arb_take;
   logic              arb_any;
   logic              arb_winner;

   assign rack     = {rack1, rack0};
   // The pick is only consumed in IDLE; requests arriving in EXEC/RESP
   // simply stay pending and do not disturb the pointer.
   assign arb_take = (state_q == IDLE);

   rr_arb2 u_rr_arb2 (
      .clk     (CLK),
      .rst     (RST),
      .req     ({req1, req0}),
      .take    (arb_take),
      .any_req (arb_any),
      .winner  (arb_winner)
   );

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      gnt_d    = 2'b00;
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rzero_d  = rzero_q;
      rneg_d   = rneg_q;
      rovf_d   = rovf_q;
      alu_op_d = alu_op_q;
      alu_a_d  = alu_a_q;
      alu_b_d  = alu_b_q;

      case (state_q)
         IDLE: begin
            if (arb_any) begin
               alu_op_d = arb_winner ? op1 : op0;
               alu_a_d  = arb_winner ? a1  : a0;
               alu_b_d  = arb_winner ? b1  : b0;
               gnt_d    = req_onehot(arb_winner);
               owner_d  = arb_winner;
               state_d  = EXEC;
            end
         end

         EXEC: begin
            // ALU inputs have been stable for a full cycle; sample it.
            rdata_d  = alu_out;
            rzero_d  = alu_zero;
            rneg_d   = alu_neg;
            rovf_d   = alu_ovf;
            rvalid_d = req_onehot(owner_q);
            state_d  = RESP;
         end

         RESP: begin
            // Only the owner's ack releases the result.
            if (rack[owner_q]) begin
               rvalid_d = 2'b00;
               state_d  = IDLE;
            end
         end

         default: begin
            rvalid_d = 2'b00;
            state_d  = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= IDLE;
         owner_q  <= 1'b0;
         gnt_q    <= 2'b00;
         rvalid_q <= 2'b00;
         rdata_q  <= '0;
         rzero_q  <= 1'b0;
         rneg_q   <= 1'b0;
         rovf_q   <= 1'b0;
         alu_op_q <= ALU_SLL;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         gnt_q    <= gnt_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         rzero_q  <= rzero_d;
         rneg_q   <= rneg_d;
         rovf_q   <= rovf_d;
         alu_op_q <= alu_op_d;
         alu_a_q  <= alu_a_d;
         alu_b_q  <= alu_b_d;
      end
   end

   assign gnt0    = gnt_q[0];
   assign gnt1    = gnt_q[1];
   assign rvalid0 = rvalid_q[0];
   assign rvalid1 = rvalid_q[1];
   assign rdata   = rdata_q;
   assign rzero   = rzero_q;
   assign rneg    = rneg_q;
   assign rovf    = rovf_q;
   assign alu_op  = alu_op_q;
   assign alu_a   = alu_a_q;
   assign alu_b   = alu_b_q;

`ifdef ALU_ARB_STATS_EN
   // ------------------------------------------------------------------
   // Saturating statistics counters
   // ------------------------------------------------------------------
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] gcnt0_q,        gcnt0_d;
   logic [CNT_W-1:0] gcnt1_q,        gcnt1_d;
   logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

   always_comb begin
      gcnt0_d        = gcnt0_q;
      gcnt1_d        = gcnt1_q;
      conflict_cnt_d = conflict_cnt_q;
      // Counted on the edge that raises the grant pulse.
      if (gnt_d[0] && (gcnt0_q != '1)) begin
         gcnt0_d = gcnt0_q + CNT_ONE;
      end
      if (gnt_d[1] && (gcnt1_q != '1)) begin
         gcnt1_d = gcnt1_q + CNT_ONE;
      end
      if ((state_q == IDLE) && req0 && req1 && (conflict_cnt_q != '1)) begin
         conflict_cnt_d = conflict_cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         gcnt0_q        <= '0;
         gcnt1_q        <= '0;
         conflict_cnt_q <= '0;
      end else begin
         gcnt0_q        <= gcnt0_d;
         gcnt1_q        <= gcnt1_d;
         conflict_cnt_q <= conflict_cnt_d;
      end
   end

   assign gcnt0        = gcnt0_q;
   assign gcnt1        = gcnt1_q;
   assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter

module tb_alu_arbiter;
   import cpu_types_pkg::*;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0, rack0 = 1'b0, rack1 = 1'b0;
   aluop_t      op0 = ALU_SLL, op1 = ALU_SLL;
   logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic        gnt0, gnt1, rvalid0, rvalid1, rzero, rneg, rovf;
   logic [31:0] rdata, alu_a, alu_b, alu_out;
   aluop_t      alu_op;
   logic        alu_zero, alu_neg, alu_ovf;
`ifdef ALU_ARB_STATS_EN
   logic [CNT_W-1:0] gcnt0, gcnt1, conflict_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   alu_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RST(RST),
      .req0(req0), .req1(req1), .op0(op0), .op1(op1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rack0(rack0), .rack1(rack1),
      .rdata(rdata), .rzero(rzero), .rneg(rneg), .rovf(rovf),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_out(alu_out), .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_ovf(alu_ovf)
`ifdef ALU_ARB_STATS_EN
      , .gcnt0(gcnt0), .gcnt1(gcnt1), .conflict_cnt(conflict_cnt)
`endif
   );

   // Reference ALU attached to the arbiter's drive ports.
   logic [31:0] r;
   always_comb begin
      r       = 32'h0;
      alu_ovf = 1'b0;
      case (alu_op)
         ALU_SLL:  r = alu_a << alu_b[4:0];
         ALU_SRL:  r = alu_a >> alu_b[4:0];
         ALU_SRA:  r = $unsigned($signed(alu_a) >>> alu_b[4:0]);
         ALU_ADD:  begin r = alu_a + alu_b; alu_ovf = (alu_a[31] == alu_b[31]) && (r[31] != alu_a[31]); end
         ALU_SUB:  begin r = alu_a - alu_b; alu_ovf = (alu_a[31] != alu_b[31]) && (r[31] != alu_a[31]); end
         ALU_AND:  r = alu_a & alu_b;
         ALU_OR:   r = alu_a | alu_b;
         ALU_XOR:  r = alu_a ^ alu_b;
         ALU_SLT:  r = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
         ALU_SLTU: r = (alu_a < alu_b) ? 32'd1 : 32'd0;
         default:  r = 32'h0;
      endcase
      alu_out  = r;
      alu_zero = (r == 32'h0);
      alu_neg  = r[31];
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      checks++; if ({gnt0, gnt1, rvalid0, rvalid1, rzero, rneg, rovf} !== 7'd0) begin failures++; $display("FAIL reset_ctrl got=%b exp=0", {gnt0, gnt1, rvalid0, rvalid1, rzero, rneg, rovf}); end
      checks++; if ({rdata, alu_a, alu_b} !== 96'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", {rdata, alu_a, alu_b}); end
      checks++; if (alu_op !== ALU_SLL) begin failures++; $display("FAIL reset_op got=%h exp=%h", alu_op, ALU_SLL); end
      // drive requester 1 into RESP, then reset asynchronously mid-cycle
      op1 = ALU_OR; a1 = 32'h0000_00F0; b1 = 32'h0000_000F; req1 = 1'b1;
      tick(); req1 = 1'b0;
      tick();
      checks++; if (rvalid1 !== 1'b1 || rdata !== 32'h0000_00FF) begin failures++; $display("FAIL pre_reset_resp got=%b/%h exp=1/000000ff", rvalid1, rdata); end
      #2 RST = 1'b1;
      #1;
      checks++; if ({gnt0, gnt1, rvalid0, rvalid1, rzero, rneg, rovf} !== 7'd0) begin failures++; $display("FAIL async_reset_ctrl got=%b exp=0", {gnt0, gnt1, rvalid0, rvalid1, rzero, rneg, rovf}); end
      checks++; if ({rdata, alu_a, alu_b} !== 96'd0 || alu_op !== ALU_SLL) begin failures++; $display("FAIL async_reset_data got=%h op=%h exp=0", {rdata, alu_a, alu_b}, alu_op); end
      @(posedge CLK); #1 RST = 1'b0;
      op0 = ALU_ADD; a0 = 32'd3; b0 = 32'd4; req0 = 1'b1;
      tick();
      checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || rvalid0 !== 1'b0) begin failures++; $display("FAIL add_gnt got=%b%b%b exp=100", gnt0, gnt1, rvalid0); end
      req0 = 1'b0;
      tick();
      checks++; if (rvalid0 !== 1'b1 || gnt0 !== 1'b0) begin failures++; $display("FAIL add_rvalid got=%b/%b exp=1/0", rvalid0, gnt0); end
      checks++; if (rdata !== 32'd7 || rzero !== 1'b0) begin failures++; $display("FAIL add_result got=%h/%b exp=7/0", rdata, rzero); end
      rack0 = 1'b1; tick(); rack0 = 1'b0;
      checks++; if (rvalid0 !== 1'b0) begin failures++; $display("FAIL add_release got=%b exp=0", rvalid0); end
   endtask

   task automatic test_overflow();
      op1 = ALU_ADD; a1 = 32'h7FFF_FFFF; b1 = 32'h0000_0001; req1 = 1'b1;
      tick();
      checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin failures++; $display("FAIL ovf_gnt got=%b%b exp=10", gnt1, gnt0); end
      req1 = 1'b0;
      tick();
      checks++; if (rvalid1 !== 1'b1 || rdata !== 32'h8000_0000) begin failures++; $display("FAIL ovf_result got=%b/%h exp=1/80000000", rvalid1, rdata); end
      checks++; if ({rzero, rneg, rovf} !== 3'b011) begin failures++; $display("FAIL ovf_flags got=%b exp=011", {rzero, rneg, rovf}); end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (rvalid1 !== 1'b1 || rdata !== 32'h8000_0000 || rovf !== 1'b1) begin failures++; $display("FAIL ovf_hold%0d got=%b/%h exp=1/80000000", i, rvalid1, rdata); end
      end
      rack1 = 1'b1; tick(); rack1 = 1'b0;
      checks++; if (rvalid1 !== 1'b0) begin failures++; $display("FAIL ovf_release got=%b exp=0", rvalid1); end
   endtask

   task automatic test_stray_ack();
      op0 = ALU_AND; a0 = 32'h0000_F0F0; b0 = 32'h0000_FF00; req0 = 1'b1;
      tick();
      checks++; if (gnt0 !== 1'b1) begin failures++; $display("FAIL stray_gnt0 got=%b exp=1", gnt0); end
      req0 = 1'b0;
      tick();
      checks++; if (rvalid0 !== 1'b1 || rdata !== 32'h0000_F000) begin failures++; $display("FAIL stray_result got=%b/%h exp=1/0000f000", rvalid0, rdata); end
      // requester 1 raises a request and a stray ack while 0 owns the result
      op1 = ALU_XOR; a1 = 32'd5; b1 = 32'd3; req1 = 1'b1; rack1 = 1'b1;
      tick();
      checks++; if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || gnt1 !== 1'b0) begin failures++; $display("FAIL stray_ignored got=%b%b%b exp=100", rvalid0, rvalid1, gnt1); end
      rack1 = 1'b0; rack0 = 1'b1;
      tick();
      checks++; if (rvalid0 !== 1'b0 || gnt1 !== 1'b0) begin failures++; $display("FAIL stray_release got=%b/%b exp=0/0", rvalid0, gnt1); end
      rack0 = 1'b0;
      tick();
      checks++; if (gnt1 !== 1'b1) begin failures++; $display("FAIL pending_gnt1 got=%b exp=1", gnt1); end
      req1 = 1'b0;
      tick();
      checks++; if (rvalid1 !== 1'b1 || rdata !== 32'd6) begin failures++; $display("FAIL pending_result got=%b/%h exp=1/6", rvalid1, rdata); end
      rack1 = 1'b1; tick(); rack1 = 1'b0;
   endtask

   task automatic test_zero_flag();
      op0 = ALU_SUB; a0 = 32'd5; b0 = 32'd5; req0 = 1'b1;
      tick(); req0 = 1'b0;
      tick();
      checks++; if (rvalid0 !== 1'b1 || rdata !== 32'd0 || rzero !== 1'b1) begin failures++; $display("FAIL sub_zero got=%b/%h/%b exp=1/0/1", rvalid0, rdata, rzero); end
      rack0 = 1'b1; tick(); rack0 = 1'b0;
      op0 = ALU_SLT; a0 = 32'hFFFF_FFFF; b0 = 32'd1; req0 = 1'b1;
      tick(); req0 = 1'b0;
      tick();
      checks++; if (rdata !== 32'd1 || rzero !== 1'b0 || rneg !== 1'b0) begin failures++; $display("FAIL slt got=%h/%b/%b exp=1/0/0", rdata, rzero, rneg); end
      rack0 = 1'b1; tick(); rack0 = 1'b0;
      checks++; if (alu_a !== 32'hFFFF_FFFF || alu_op !== ALU_SLT) begin failures++; $display("FAIL alu_hold got=%h/%h exp=ffffffff/8", alu_a, alu_op); end
      // undefined op passes straight through to the ALU
      op0 = aluop_t'(4'hE); a0 = 32'd9; b0 = 32'd9; req0 = 1'b1;
      tick(); req0 = 1'b0;
      checks++; if (alu_op !== aluop_t'(4'hE)) begin failures++; $display("FAIL undef_op got=%h exp=e", alu_op); end
      tick();
      rack0 = 1'b1; tick(); rack0 = 1'b0;
   endtask

   task automatic test_back_to_back();
      RST = 1'b1; tick(); RST = 1'b0;
      op0 = ALU_ADD; a0 = 32'd1; b0 = 32'd1;
      op1 = ALU_SUB; a1 = 32'd10; b1 = 32'd3;
      req0 = 1'b1; req1 = 1'b1; rack0 = 1'b1; rack1 = 1'b1;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         logic g, w;
         tick();
         g = ((cyc % 3) == 1);
         w = (((cyc - 1) / 3) % 2) == 1;
         checks++; if (gnt0 !== (g && !w) || gnt1 !== (g && w)) begin failures++; $display("FAIL rr_cyc%0d got=%b%b exp=%b%b", cyc, gnt1, gnt0, g && w, g && !w); end
         if ((cyc % 3) == 2) begin
            checks++; if (rdata !== (w ? 32'd7 : 32'd2)) begin failures++; $display("FAIL rr_data%0d got=%h exp=%h", cyc, rdata, w ? 32'd7 : 32'd2); end
         end
      end
      req0 = 1'b0; req1 = 1'b0; rack0 = 1'b0; rack1 = 1'b0;
      tick();
   endtask

`ifdef ALU_ARB_STATS_EN
   task automatic test_stats();
      RST = 1'b1; tick(); RST = 1'b0;
      op0 = ALU_ADD; op1 = ALU_ADD;
      req0 = 1'b1; req1 = 1'b1; rack0 = 1'b1; rack1 = 1'b1;
      repeat (10) tick();
      req1 = 1'b0;
      repeat (3) tick();
      req0 = 1'b0;
      repeat (3) tick();
      checks++; if (gcnt0 !== 4'd3 || gcnt1 !== 4'd2) begin failures++; $display("FAIL stats_gcnt got=%0d/%0d exp=3/2", gcnt0, gcnt1); end
      checks++; if (conflict_cnt !== 4'd4) begin failures++; $display("FAIL stats_conflict got=%0d exp=4", conflict_cnt); end
      req0 = 1'b1;
      repeat (42) tick();
      req0 = 1'b0;
      repeat (3) tick();
      checks++; if (gcnt0 !== 4'hF || gcnt1 !== 4'd2 || conflict_cnt !== 4'd4) begin failures++; $display("FAIL stats_sat got=%h/%h/%h exp=f/2/4", gcnt0, gcnt1, conflict_cnt); end
      rack0 = 1'b0; rack1 = 1'b0;
   endtask
`endif

   initial begin
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
      test_reset();
      test_overflow();
      test_stray_ack();
      test_zero_flag();
      test_back_to_back();
`ifdef ALU_ARB_STATS_EN
      test_stats();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
